// File: rtl/main_fsm_pkg.sv
// rtl/main_fsm_pkg.sv - main control FSM states, datapath mux encodings and control vector
package main_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_UNDEF  = 4'd10
   } state_e;

   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_BR    = 2'b10;
   localparam logic [1:0] OP_UNDEF = 2'b11;

   localparam logic [1:0] SRCA_RN     = 2'b00;
   localparam logic [1:0] SRCA_PC     = 2'b01;
   localparam logic [1:0] SRCA_ALUOUT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // fetch is the raw "in FETCH" flag; the top qualifies it with mem_ready
   typedef struct packed {
      logic       fetch;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       illegal;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/main_fsm_out_dec.sv
// rtl/main_fsm_out_dec.sv - Moore output decode: state -> control vector
module main_fsm_out_dec
   import main_fsm_pkg::*;
(
   input  logic [3:0]        state_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_t c;

   always_comb begin
      c = '0;
      case (state_i)
         S_FETCH: begin
            c.fetch      = 1'b1;
            c.adr_src    = 1'b0;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALU;
         end
         S_DECODE: begin
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALU;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RN;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = RES_RDATA;
            c.reg_w      = 1'b1;
         end
         S_MEMWR: begin
            c.adr_src = 1'b1;
            c.mem_w   = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_b = SRCB_REG;
            c.alu_op    = 1'b1;
         end
         S_EXECI: begin
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = 1'b1;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_w      = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = SRCA_ALUOUT;
            c.alu_src_b  = SRCB_IMM;
            c.result_src = RES_ALU;
            c.branch     = 1'b1;
         end
         S_UNDEF: c.illegal = 1'b1;
         default: c = '0;
      endcase
   end

   assign ctrl_o = c;

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle main control FSM: state register and next-state logic
module main_fsm
   import main_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       ir_write,
   output logic       next_pc,
   output logic       reg_w,
   output logic       mem_w,
   output logic       branch,
   output logic       alu_op,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       illegal
);

   state_e             state_q, state_d;
   logic [CTRL_W-1:0]  ctrl_vec;
   ctrl_t              ctrl;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_UNDEF;
            endcase
         end
         S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   main_fsm_out_dec u_out_dec (
      .state_i (state_q),
      .ctrl_o  (ctrl_vec)
   );

   assign ctrl = ctrl_t'(ctrl_vec);

   // strobes are forced low combinationally while reset is held
   assign ir_write   = ctrl.fetch & mem_ready & reset_n;
   assign next_pc    = ctrl.fetch & mem_ready & reset_n;
   assign reg_w      = ctrl.reg_w & reset_n;
   assign mem_w      = ctrl.mem_w & reset_n;
   assign branch     = ctrl.branch & reset_n;
   assign illegal    = ctrl.illegal & reset_n;
   assign alu_op     = ctrl.alu_op;
   assign adr_src    = ctrl.adr_src;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign result_src = ctrl.result_src;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - scoreboard bench for main_fsm against an instruction-level reference model
module tb_main_fsm;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] op = 2'b00;
   logic [5:0] funct = 6'd0;
   logic       mem_ready = 1'b0;
   logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src, illegal;
   logic [1:0] alu_src_a, alu_src_b, result_src;

   main_fsm dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .funct      (funct),
      .mem_ready  (mem_ready),
      .ir_write   (ir_write),
      .next_pc    (next_pc),
      .reg_w      (reg_w),
      .mem_w      (mem_w),
      .branch     (branch),
      .alu_op     (alu_op),
      .adr_src    (adr_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4,
                  ST_MEMWR = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                  ST_UNDEF = 10;

   int          total = 0;
   int          bad = 0;
   logic [13:0] exp_q[$];
   bit          skip_wait = 0;
   logic [13:0] act;

   assign act = {ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src,
                 alu_src_a, alu_src_b, result_src, illegal};

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, a, e, $time);
      end
   endtask

   // expected control vector for one cycle of an instruction phase
   function automatic logic [13:0] exp_vec(input int step, input bit mr);
      logic ir = 0, npc = 0, rw = 0, mw = 0, br = 0, ao = 0, as = 0, il = 0;
      logic [1:0] a = 2'b00, b = 2'b00, r = 2'b00;
      case (step)
         ST_FETCH:  begin a = 2'b01; b = 2'b10; r = 2'b10; ir = mr; npc = mr; end
         ST_DECODE: begin a = 2'b01; b = 2'b10; r = 2'b10; end
         ST_MEMADR: begin a = 2'b00; b = 2'b01; end
         ST_MEMRD:  as = 1;
         ST_MEMWB:  begin r = 2'b01; rw = 1; end
         ST_MEMWR:  begin as = 1; mw = 1; end
         ST_EXECR:  begin b = 2'b00; ao = 1; end
         ST_EXECI:  begin b = 2'b01; ao = 1; end
         ST_ALUWB:  begin r = 2'b00; rw = 1; end
         ST_BRANCH: begin a = 2'b10; b = 2'b01; r = 2'b10; br = 1; end
         default:   il = 1;
      endcase
      return {ir, npc, rw, mw, br, ao, as, a, b, r, il};
   endfunction

   always @(negedge clk) begin : monitor
      logic [13:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ctrl_vec", {18'd0, act}, {18'd0, e});
      end
   end

   task automatic cyc(input int step, input logic [1:0] o, input logic [5:0] f, input bit mr);
      if (!skip_wait) begin
         @(posedge clk);
         #1;
      end
      skip_wait = 0;
      op = o;
      funct = f;
      mem_ready = mr;
      exp_q.push_back(exp_vec(step, mr));
   endtask

   function automatic logic [1:0] rop();
      return 2'($urandom_range(0, 3));
   endfunction

   function automatic logic [5:0] rfn();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // op/funct carry junk outside DECODE/MEMADR so late sampling would show up
   task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input int fst, input int mst);
      for (int i = 0; i < fst; i++) cyc(ST_FETCH, rop(), rfn(), 0);
      cyc(ST_FETCH, rop(), rfn(), 1);
      cyc(ST_DECODE, o, f, rbit());
      case (o)
         2'b00: begin
            cyc(f[5] ? ST_EXECI : ST_EXECR, rop(), rfn(), rbit());
            cyc(ST_ALUWB, rop(), rfn(), rbit());
         end
         2'b01: begin
            cyc(ST_MEMADR, o, f, rbit());
            if (f[0]) begin
               for (int i = 0; i < mst; i++) cyc(ST_MEMRD, rop(), rfn(), 0);
               cyc(ST_MEMRD, rop(), rfn(), 1);
               cyc(ST_MEMWB, rop(), rfn(), rbit());
            end else begin
               for (int i = 0; i < mst; i++) cyc(ST_MEMWR, rop(), rfn(), 0);
               cyc(ST_MEMWR, rop(), rfn(), 1);
            end
         end
         2'b10: cyc(ST_BRANCH, rop(), rfn(), rbit());
         default: cyc(ST_UNDEF, rop(), rfn(), rbit());
      endcase
   endtask

   initial begin
      mem_ready = 1'b1;
      #2;
      check("rst_ir_write", {31'd0, ir_write}, 32'd0);
      check("rst_next_pc", {31'd0, next_pc}, 32'd0);
      check("rst_strobes", {28'd0, reg_w, mem_w, branch, illegal}, 32'd0);
      check("rst_fetch_mux", {26'd0, alu_src_a, alu_src_b, result_src}, {26'd0, 6'b011010});
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      skip_wait = 1;

      run_instr(2'b00, 6'b001000, 0, 0);
      run_instr(2'b01, 6'b011001, 1, 2);
      run_instr(2'b01, 6'b011000, 0, 2);
      run_instr(2'b10, rfn(), 0, 0);
      run_instr(2'b11, rfn(), 2, 0);
      run_instr(2'b00, 6'b101000, 0, 0);

      for (int n = 0; n < 150; n++)
         run_instr(rop(), rfn(), $urandom_range(0, 2), $urandom_range(0, 3));

      cyc(ST_FETCH, rop(), rfn(), 1);
      cyc(ST_DECODE, 2'b01, 6'b011000, 1);
      cyc(ST_MEMADR, 2'b01, 6'b011000, 0);
      cyc(ST_MEMWR, rop(), rfn(), 0);
      @(negedge clk);
      #1;
      check("midwr_mem_w_before", {31'd0, mem_w}, 32'd1);
      mem_ready = 1'b1;
      reset_n = 1'b0;
      #1;
      check("midwr_mem_w_reset", {31'd0, mem_w}, 32'd0);
      check("midwr_ir_write_reset", {31'd0, ir_write}, 32'd0);
      check("midwr_fetch_mux", {26'd0, alu_src_a, alu_src_b, result_src}, {26'd0, 6'b011010});
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      skip_wait = 1;
      run_instr(rop(), rfn(), 2, 1);

      for (int n = 0; n < 20; n++)
         run_instr(rop(), rfn(), $urandom_range(0, 2), $urandom_range(0, 3));

      @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
